// File: rtl/spi_mst_ctrl.sv
// SPI bus master with a 128-bit transmit/receive window behind a small control/status
// register pair. Word size, scl polarity/phase and scl rate are fixed at build time.
module spi_mst_ctrl #(
  parameter int MODE_16B = 0,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int CLK_DIV  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] mst_wfifo,
  input  logic [7:0]   mst_ctrl,
  output logic [127:0] mst_rfifo,
  output logic [7:0]   mst_status,
  output logic         scl,
  output logic         ss,
  output logic         mosi,
  input  logic         miso
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  localparam logic       SCL_IDLE = (CPOL != 0);
  localparam logic       PHASE1   = (CPHA != 0);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t       state, state_nxt;
  logic [7:0]   div_cnt;
  logic [8:0]   edge_cnt;
  logic [8:0]   edge_total;
  logic [8:0]   len_ext;
  logic [127:0] tx_sh;
  logic [3:0]   len_q;
  logic         busy, done;
  logic         start_q, start_prev;
  logic         div_done, start_rise;
  logic         lead, smp_edge, drv_edge;
  logic         do_start, do_edge, do_finish;
  logic [6:0]   rx_idx;
  logic         unused_ctrl;

  assign unused_ctrl = ^mst_ctrl[6:4];

  assign div_done   = (div_cnt == DIV_LAST);
  assign start_rise = start_q & ~start_prev;
  assign len_ext    = 9'(len_q) + 9'd1;

  // Total scl edges for the latched length: two per bit, capped at 128 bits.
  always_comb begin
    if (MODE_16B != 0) begin
      edge_total = (len_q > 4'd7) ? 9'd256 : (len_ext << 5);
    end else begin
      edge_total = len_ext << 4;
    end
  end

  // Even edge count means the next edge leaves the idle level (leading edge).
  assign lead     = ~edge_cnt[0];
  assign rx_idx   = 7'd127 - edge_cnt[7:1];
  assign smp_edge = do_edge & (lead ^ PHASE1);
  assign drv_edge = do_edge & (PHASE1 ? lead
                                      : (~lead & (edge_cnt != (edge_total - 9'd1))));

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_edge   = 1'b0;
    do_finish = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_nxt = SETUP;
          do_start  = 1'b1;
        end
      end
      SETUP: begin
        if (div_done) begin
          state_nxt = XFER;
          do_edge   = 1'b1;
        end
      end
      XFER: begin
        if (div_done) begin
          if (edge_cnt == edge_total) begin
            state_nxt = HOLD;
          end else begin
            do_edge = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_done) begin
          state_nxt = IDLE;
          do_finish = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q    <= 1'b0;
      start_prev <= 1'b0;
      div_cnt    <= 8'd0;
      edge_cnt   <= 9'd0;
    end else begin
      start_q    <= mst_ctrl[7];
      start_prev <= start_q;
      if (state == IDLE || div_done) begin
        div_cnt <= 8'd0;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (do_start) begin
        edge_cnt <= 9'd0;
      end else if (do_edge) begin
        edge_cnt <= edge_cnt + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ss    <= 1'b1;
      scl   <= SCL_IDLE;
    end else begin
      if (do_start) begin
        len_q <= mst_ctrl[3:0];
        busy  <= 1'b1;
        done  <= 1'b0;
        ss    <= 1'b0;
      end
      if (do_edge) begin
        scl <= ~scl;
      end
      if (do_finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        ss   <= 1'b1;
        scl  <= SCL_IDLE;
      end
    end
  end

  // Phase 0 presents bit 127 together with ss falling, so the shifter is
  // preloaded one bit ahead; phase 1 waits for the first leading edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh <= '0;
      mosi  <= 1'b0;
    end else begin
      if (do_start) begin
        if (PHASE1) begin
          tx_sh <= mst_wfifo;
          mosi  <= 1'b0;
        end else begin
          tx_sh <= {mst_wfifo[126:0], 1'b0};
          mosi  <= mst_wfifo[127];
        end
      end else if (drv_edge) begin
        tx_sh <= {tx_sh[126:0], 1'b0};
        mosi  <= tx_sh[127];
      end
      if (do_finish) begin
        mosi <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_rfifo <= '0;
    end else if (do_start) begin
      mst_rfifo <= '0;
    end else if (smp_edge) begin
      mst_rfifo[rx_idx] <= miso;
    end
  end

  assign mst_status = {busy, done, 2'b00, len_q};

endmodule

// File: tb/tb_spi_mst_ctrl.sv
// Scoreboard bench for spi_mst_ctrl in two build configurations: expectations are
// queued when a transfer is launched and checked by a monitor when busy falls.
module tb_spi_mst_ctrl;

  localparam int DIV_A = 4;
  localparam int DIV_B = 2;

  typedef struct {
    logic [127:0] rx;
    logic [127:0] tx;
    logic [7:0]   st;
    int           periods;
    int           ss_low;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] wfifo_a, wfifo_b, rfifo_a, rfifo_b;
  logic [7:0]   ctrl_a, ctrl_b, status_a, status_b;
  logic         scl_a, ss_a, mosi_a, miso_a;
  logic         scl_b, ss_b, mosi_b, miso_b;
  logic         loop_a;
  logic [127:0] dev_pat, dev_sh;
  logic         dev_ss_q, dev_scl_q;

  spi_mst_ctrl #(.MODE_16B(0), .CPOL(0), .CPHA(0), .CLK_DIV(DIV_A)) u_a (
    .clk(clk), .rst(rst), .mst_wfifo(wfifo_a), .mst_ctrl(ctrl_a), .mst_rfifo(rfifo_a),
    .mst_status(status_a), .scl(scl_a), .ss(ss_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_mst_ctrl #(.MODE_16B(1), .CPOL(1), .CPHA(1), .CLK_DIV(DIV_B)) u_b (
    .clk(clk), .rst(rst), .mst_wfifo(wfifo_b), .mst_ctrl(ctrl_b), .mst_rfifo(rfifo_b),
    .mst_status(status_b), .scl(scl_b), .ss(ss_b), .mosi(mosi_b), .miso(miso_b)
  );

  assign miso_a = loop_a ? mosi_a : dev_sh[127];
  assign miso_b = mosi_b;

  int   checks   = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  logic         prev_busy[2];
  logic         prev_scl[2];
  int           scl_cnt[2];
  int           ss_cnt[2];
  int           bad_cnt[2];
  logic [127:0] mosi_cap[2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Slave for u_a: presents bit 127 when ss falls, shifts on each scl falling edge.
  initial begin
    dev_sh    = '0;
    dev_ss_q  = 1'b1;
    dev_scl_q = 1'b0;
  end

  always @(negedge clk) begin
    if (!ss_a && dev_ss_q) begin
      dev_sh = dev_pat;
    end else if (!ss_a && !scl_a && dev_scl_q) begin
      dev_sh = dev_sh << 1;
    end
    dev_ss_q  = ss_a;
    dev_scl_q = scl_a;
  end

  task automatic mon_step(input int i, input logic busy, input logic ss, input logic scl,
                          input logic mosi, input logic [127:0] rx, input logic [7:0] st);
    exp_t  e;
    bit    have;
    string tag;
    tag  = (i == 0) ? "a" : "b";
    have = 1'b0;
    if (busy && !prev_busy[i]) begin
      scl_cnt[i]  = 0;
      ss_cnt[i]   = 0;
      bad_cnt[i]  = 0;
      mosi_cap[i] = '0;
    end
    if (!ss) begin
      ss_cnt[i]++;
      if (!busy) bad_cnt[i]++;
    end
    if (scl && !prev_scl[i]) begin
      if (scl_cnt[i] < 128) mosi_cap[i][127 - scl_cnt[i]] = mosi;
      scl_cnt[i]++;
    end
    if (!busy && prev_busy[i]) begin
      if (i == 0 && q_a.size() > 0) begin
        e = q_a.pop_front();
        have = 1'b1;
      end else if (i == 1 && q_b.size() > 0) begin
        e = q_b.pop_front();
        have = 1'b1;
      end else begin
        check($sformatf("%s.unexpected_xfer", tag), 128'd1, 128'd0);
      end
      if (have) begin
        check($sformatf("%s.rfifo", tag), rx, e.rx);
        check($sformatf("%s.status", tag), 128'(st), 128'(e.st));
        check($sformatf("%s.scl_periods", tag), 128'(scl_cnt[i]), 128'(e.periods));
        check($sformatf("%s.ss_low_cycles", tag), 128'(ss_cnt[i]), 128'(e.ss_low));
        check($sformatf("%s.mosi_bits", tag), mosi_cap[i], e.tx);
        check($sformatf("%s.ss_low_not_busy", tag), 128'(bad_cnt[i]), 128'd0);
      end
    end
    prev_busy[i] = busy;
    prev_scl[i]  = scl;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_busy[0] = 1'b0;
      prev_busy[1] = 1'b0;
      prev_scl[0]  = scl_a;
      prev_scl[1]  = scl_b;
      scl_cnt[0]   = 0;
      scl_cnt[1]   = 0;
    end else begin
      mon_step(0, status_a[7], ss_a, scl_a, mosi_a, rfifo_a, status_a);
      mon_step(1, status_b[7], ss_b, scl_b, mosi_b, rfifo_b, status_b);
    end
  end

  task automatic launch(input int i, input logic [127:0] wf, input logic [3:0] len,
                        input logic [127:0] exp_rx, input int periods, input bit push);
    exp_t e;
    e.rx      = exp_rx;
    e.tx      = wf & ~((128'd1 << (128 - periods)) - 128'd1);
    e.st      = {1'b0, 1'b1, 2'b00, len};
    e.periods = periods;
    e.ss_low  = (2 * periods + 2) * ((i == 0) ? DIV_A : DIV_B);
    if (push) begin
      if (i == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    @(negedge clk);
    if (i == 0) begin
      wfifo_a = wf;
      ctrl_a  = {1'b1, 3'b000, len};
    end else begin
      wfifo_b = wf;
      ctrl_b  = {1'b1, 3'b000, len};
    end
  endtask

  task automatic wait_busy(input int i, input logic level, input int budget, input string what);
    int n;
    n = 0;
    while ((((i == 0) ? status_a[7] : status_b[7]) !== level) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check($sformatf("timeout_%s", what), 128'(n), 128'(budget - 1));
  endtask

  task automatic finish_xfer(input int i);
    wait_busy(i, 1'b1, 20, "busy_rise");
    wait_busy(i, 1'b0, 3000, "busy_fall");
    repeat (2) @(negedge clk);
  endtask

  task automatic drop_start(input int i);
    @(negedge clk);
    if (i == 0) ctrl_a[7] = 1'b0;
    else        ctrl_b[7] = 1'b0;
  endtask

  initial begin
    int n;
    ctrl_a  = '0;
    ctrl_b  = '0;
    wfifo_a = '0;
    wfifo_b = '0;
    loop_a  = 1'b1;
    dev_pat = '0;
    repeat (3) @(negedge clk);

    check("rst.a.scl", 128'(scl_a), 128'd0);
    check("rst.a.ss", 128'(ss_a), 128'd1);
    check("rst.a.mosi", 128'(mosi_a), 128'd0);
    check("rst.a.rfifo", rfifo_a, 128'd0);
    check("rst.a.status", 128'(status_a), 128'd0);
    check("rst.b.scl", 128'(scl_b), 128'd1);
    check("rst.b.ss", 128'(ss_b), 128'd1);
    check("rst.b.mosi", 128'(mosi_b), 128'd0);
    check("rst.b.rfifo", rfifo_b, 128'd0);
    check("rst.b.status", 128'(status_b), 128'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    loop_a  = 1'b0;
    dev_pat = {4{32'hCAFEEFAB}};
    launch(0, {4{32'h12345678}}, 4'd7, {64'hCAFEEFABCAFEEFAB, 64'h0}, 64, 1'b1);
    finish_xfer(0);
    drop_start(0);

    loop_a = 1'b1;
    launch(0, {16{8'h5A}}, 4'd5, {48'h5A5A5A5A5A5A, 80'h0}, 48, 1'b1);
    finish_xfer(0);
    drop_start(0);

    loop_a  = 1'b0;
    dev_pat = {4{32'hBABEFACE}};
    launch(0, {16{8'h5A}}, 4'd5, {48'hBABEFACEBABE, 80'h0}, 48, 1'b1);
    finish_xfer(0);
    drop_start(0);

    launch(1, 128'h0123456789ABCDEF_FEDCBA9876543210, 4'd7,
           128'h0123456789ABCDEF_FEDCBA9876543210, 128, 1'b1);
    finish_xfer(1);
    drop_start(1);
    launch(1, 128'hDEADBEEF_00FF00FF_12345678_9ABCDEF0, 4'd15,
           128'hDEADBEEF_00FF00FF_12345678_9ABCDEF0, 128, 1'b1);
    finish_xfer(1);
    drop_start(1);

    // Start held high long after completion must not retrigger.
    loop_a = 1'b1;
    launch(0, {8'hC3, 120'h0}, 4'd0, {8'hC3, 120'h0}, 8, 1'b1);
    finish_xfer(0);
    repeat (300) @(negedge clk);
    check("held.busy", 128'(status_a[7]), 128'd0);
    check("held.done", 128'(status_a[6]), 128'd1);
    drop_start(0);
    repeat (4) @(negedge clk);
    launch(0, {16'hA55A, {112{1'b1}}}, 4'd1, {16'hA55A, 112'h0}, 16, 1'b1);
    finish_xfer(0);
    drop_start(0);

    // Abort with reset in the middle of a transfer.
    launch(0, {4{32'h89ABCDEF}}, 4'd7, 128'd0, 64, 1'b0);
    n = 0;
    while (scl_cnt[0] < 20 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) check("timeout_bit20", 128'(scl_cnt[0]), 128'd20);
    #2 rst = 1'b1;
    #1;
    check("abort.ss", 128'(ss_a), 128'd1);
    check("abort.scl", 128'(scl_a), 128'd0);
    check("abort.mosi", 128'(mosi_a), 128'd0);
    check("abort.status", 128'(status_a), 128'd0);
    check("abort.rfifo", rfifo_a, 128'd0);
    ctrl_a = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);

    launch(0, {4{32'h89ABCDEF}}, 4'd15, {4{32'h89ABCDEF}}, 128, 1'b1);
    finish_xfer(0);
    drop_start(0);
    repeat (4) @(negedge clk);

    check("a.queue_empty", 128'(q_a.size()), 128'd0);
    check("b.queue_empty", 128'(q_b.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
